pll_reset_sequencer: RTL

Sequences bring-up of the system PLL, which is clocked from the 50 MHz board clock. It applies a timed reset pulse to the PLL and synchronises and qualifies the PLL `locked` output. Only after lock has been stable for a programmable time does it release the core's system reset. It runs on the free-running reference clock, restarts the PLL on lock loss, lock timeout or software request, and reports status to the SoC glue logic.

---
 rtl/pll_reset_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: timed PLL reset pulse, synchronised lock qualification,
// and system reset release once lock has held for a programmable time.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       req_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_fail,
  output logic [7:0] relock_count,
  output logic [1:0] state
);

  localparam int unsigned MAX_RS  = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_RS > LOCK_TIMEOUT_CYCLES) ? MAX_RS : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_sync;
  logic             w_lk_s;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_lk_s    = r_sync[1];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign state     = r_state;

  // Two-flop synchroniser: the only consumer of raw pll_locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pll_locked};
    end
  end

  // Sequencer; outputs are set on the transition edge so they track r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RESET_PLL;
      r_cnt        <= '0;
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      lock_fail    <= 1'b0;
      relock_count <= '0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
            pll_rst <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_LOCK: begin
          if (req_relock) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
            pll_rst <= 1'b1;
          end else if (w_lk_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TMO_LAST) begin
            r_state   <= S_RESET_PLL;
            r_cnt     <= '0;
            pll_rst   <= 1'b1;
            lock_fail <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_STABLE: begin
          if (req_relock) begin
            r_state <= S_RESET_PLL;
            r_cnt   <= '0;
            pll_rst <= 1'b1;
          end else if (!w_lk_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STB_LAST) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
            lock_fail <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RUN: begin
          if (!w_lk_s || req_relock) begin
            r_state   <= S_RESET_PLL;
            r_cnt     <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            if (relock_count != 8'hFF) begin
              relock_count <= relock_count + 8'd1;
            end
          end
        end
        default: begin
          r_state   <= S_RESET_PLL;
          r_cnt     <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule
